// File: rtl/pw_meter_pkg.sv
// rtl/pw_meter_pkg.sv - shared widths, limits and FSM encoding for the pulse-width meter
package pw_meter_pkg;

  localparam int W_NT = 16;
  localparam int W_Q  = 11;

  localparam logic [W_Q-1:0] Q_MAX = {W_Q{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // A divide-by-zero request behaves as divide-by-one.
  function automatic logic [W_NT-1:0] clamp_n(input logic [W_NT-1:0] nt);
    return (nt == '0) ? W_NT'(1) : nt;
  endfunction

endpackage

// File: rtl/pw_prescaler.sv
// rtl/pw_prescaler.sv - divide-by-N prescaler; clr restarts the count with the current cycle as count 1
module pw_prescaler
  import pw_meter_pkg::*;
#(
  parameter int WIDTH = W_NT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] base;

  // clr folds into the same cycle so the starting cycle is itself counted.
  always_comb begin
    base = clr ? '0 : cnt;
    tick = en && (base == (n - ONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : (base + ONE);
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/pw_meter.sv
// rtl/pw_meter.sv - pulse-width meter: counts high time of pw_in in units of NTclk clocks
module pw_meter
  import pw_meter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pw_in,
  input  logic [W_NT-1:0] NTclk,
  output logic [W_Q-1:0]  q,
  output logic            done,
  output logic            ovf,
  output logic            busy,
  output logic            ceo
);

  logic       s1;
  logic       pw_s;
  logic       pw_d;
  logic [1:0] sync_vld;
  logic       armed;
  logic       rise;

  // sync_vld keeps the reset value of the synchronizer from looking like a real low level,
  // so a pulse already high when reset releases is not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      pw_s     <= 1'b0;
      pw_d     <= 1'b0;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      s1       <= pw_in;
      pw_s     <= s1;
      pw_d     <= pw_s;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !pw_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = pw_s && !pw_d && armed;

  state_t          state;
  state_t          state_nxt;
  logic            pre_clr;
  logic            pre_en;
  logic            finish;
  logic            tick;
  logic [W_NT-1:0] n_lat;
  logic [W_NT-1:0] n_eff;
  logic [W_Q-1:0]  cnt;

  always_comb begin
    state_nxt = state;
    pre_clr   = 1'b0;
    pre_en    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = MEAS;
          pre_clr   = 1'b1;
          pre_en    = 1'b1;
        end
      end
      MEAS: begin
        if (pw_s) begin
          pre_en = 1'b1;
        end else begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The divisor is taken live on the rise cycle and frozen for the rest of the pulse.
  assign n_eff = (state == IDLE) ? clamp_n(NTclk) : n_lat;

  pw_prescaler #(
    .WIDTH(W_NT)
  ) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (pre_clr),
    .en   (pre_en),
    .n    (n_eff),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat <= W_NT'(1);
      cnt   <= '0;
    end else if (pre_clr) begin
      n_lat <= n_eff;
      cnt   <= {{(W_Q-1){1'b0}}, tick};
    end else if (tick && (cnt != Q_MAX)) begin
      cnt <= cnt + W_Q'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        q   <= cnt;
        ovf <= (cnt == Q_MAX);
      end
    end
  end

  assign busy = (state == MEAS);
  assign ceo  = tick;

endmodule

// File: tb/tb_pw_meter.sv
// tb/tb_pw_meter.sv - self-checking bench for pw_meter
module tb_pw_meter;
  import pw_meter_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pw_in = 1'b0;
  logic [W_NT-1:0] NTclk = W_NT'(20);
  logic [W_Q-1:0]  q;
  logic            done;
  logic            ovf;
  logic            busy;
  logic            ceo;

  pw_meter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pw_in(pw_in),
    .NTclk(NTclk),
    .q    (q),
    .done (done),
    .ovf  (ovf),
    .busy (busy),
    .ceo  (ceo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nt;
    int width;
    int exp_q;
    int exp_ovf;
  } vec_t;

  typedef struct {
    int q;
    int ovf;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  vec_t tbl[8];
  int   n_chk = 0;
  int   n_err = 0;
  int   ceo_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ceo && busy) ceo_cnt++;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done with q=%0d, expected no done", q);
      end else begin
        got_e = sb.pop_front();
        check("q", int'(q), got_e.q);
        check("ovf", int'(ovf), got_e.ovf);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic pulse(input int nt, input int h, input int eq, input int eo);
    exp_t e;
    @(negedge clk);
    NTclk = W_NT'(nt);
    e.q   = eq;
    e.ovf = eo;
    sb.push_back(e);
    pw_in = 1'b1;
    repeat (h) @(negedge clk);
    pw_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("done_timeout_pending", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{20, 320, 16, 0};
    tbl[1] = '{20, 339, 16, 0};
    tbl[2] = '{20, 340, 17, 0};
    tbl[3] = '{0, 5, 5, 0};
    tbl[4] = '{1, 5, 5, 0};
    tbl[5] = '{3, 2, 0, 0};
    tbl[6] = '{1, 3000, 2047, 1};
    tbl[7] = '{1, 10, 10, 0};

    repeat (3) @(negedge clk);
    check("rst_q", int'(q), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ceo", int'(ceo), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      ceo_cnt = 0;
      pulse(tbl[i].nt, tbl[i].width, tbl[i].exp_q, tbl[i].exp_ovf);
      drain();
      if (i == 0) check("ceo_count", ceo_cnt, 16);
    end

    // NTclk changed mid-pulse must not affect the latched divisor.
    begin
      exp_t e;
      e.q = 10;
      e.ovf = 0;
      @(negedge clk);
      NTclk = W_NT'(10);
      sb.push_back(e);
      pw_in = 1'b1;
      repeat (40) @(negedge clk);
      NTclk = W_NT'(1);
      repeat (60) @(negedge clk);
      pw_in = 1'b0;
      drain();
    end

    // Pulse already high through reset release is ignored.
    rst_n = 1'b0;
    pw_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    pw_in = 1'b0;
    repeat (5) @(negedge clk);
    pulse(10, 100, 10, 0);
    drain();

    // Reset mid-measurement aborts without a done and clears q.
    NTclk = W_NT'(10);
    pw_in = 1'b1;
    repeat (30) @(negedge clk);
    check("busy_mid_pulse", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_q", int'(q), 0);
    check("abort_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    pw_in = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_after", int'(busy), 0);
    check("abort_q_after", int'(q), 0);

    // Generator loopback: 16 units of 20 clocks, then a second pulse after one low clock.
    pulse(20, 320, 16, 0);
    pulse(20, 100, 5, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
